// File: rtl/adc_scan_scheduler.sv
// Scan scheduler for an 8-channel 12-bit SPI ADC: round-robin plus priority
// channel selection, SPI framing and per-channel result registers.
module adc_scan_scheduler #(
    parameter int unsigned CLK_DIV      = 25,
    parameter int unsigned QUIET_HALVES = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             run,
    input  logic [7:0]       ch_enable,
    input  logic [7:0]       prio_req,
    output logic             ADC_CS_N,
    output logic             ADC_SCLK,
    output logic             ADC_SADDR,
    input  logic             ADC_SDAT,
    output logic             sample_valid,
    output logic [2:0]       sample_ch,
    output logic [11:0]      sample_data,
    output logic [7:0][11:0] adc_data,
    output logic             busy
);

    localparam int unsigned QUIET_CYC = (QUIET_HALVES * CLK_DIV > 0) ? QUIET_HALVES * CLK_DIV : 1;
    localparam int unsigned MAX_CNT   = (QUIET_CYC > CLK_DIV) ? QUIET_CYC : CLK_DIV;
    localparam int unsigned CNT_W     = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT_LOW,
        SHIFT_HIGH,
        QUIET
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        bit_cnt;
    logic [15:0]       cmd_sr;
    logic [11:0]       shreg;
    logic [7:0]        pend;
    logic [2:0]        rr_ptr;
    logic [2:0]        cur_ch;
    logic              cur_grant;
    logic [2:0]        pending_ch;
    logic              pending_want;

    logic              div_done, quiet_done, need_frame;
    logic              start, fall, rise, frame_end, next_bit;
    logic              prio_hit, rr_hit, sel_grant;
    logic [2:0]        prio_idx, rr_idx, rr_cand, sel_ch;
    logic [7:0]        prio_clr;
    logic              cs_low_nxt;

    assign div_done   = (cnt == CNT_W'(CLK_DIV - 1));
    assign quiet_done = (cnt == CNT_W'(QUIET_CYC - 1));
    assign need_frame = run && ((pend != 8'd0) || (ch_enable != 8'd0) || pending_want);

    // Channel choice: lowest pending priority, else next enabled after rr_ptr, else repeat.
    always_comb begin
        prio_hit = (pend != 8'd0);
        prio_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) prio_idx = 3'(i);
        end
        rr_hit  = 1'b0;
        rr_idx  = rr_ptr;
        rr_cand = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            rr_cand = rr_ptr + 3'(k);
            if (!rr_hit && ch_enable[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end
        if (prio_hit) begin
            sel_ch    = prio_idx;
            sel_grant = 1'b1;
        end else if (rr_hit) begin
            sel_ch    = rr_idx;
            sel_grant = 1'b1;
        end else begin
            sel_ch    = pending_ch;
            sel_grant = 1'b0;
        end
        prio_clr = (start && prio_hit) ? (8'd1 << prio_idx) : 8'd0;
    end

    // Next-state and frame event decode.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        fall      = 1'b0;
        rise      = 1'b0;
        frame_end = 1'b0;
        next_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (need_frame) begin
                    state_nxt = CS_SETUP;
                    start     = 1'b1;
                end
            end
            CS_SETUP: begin
                if (div_done) begin
                    state_nxt = SHIFT_LOW;
                    fall      = 1'b1;
                end
            end
            SHIFT_LOW: begin
                if (div_done) begin
                    state_nxt = SHIFT_HIGH;
                    rise      = 1'b1;
                end
            end
            SHIFT_HIGH: begin
                if (div_done) begin
                    if (bit_cnt == 4'd15) begin
                        state_nxt = QUIET;
                        frame_end = 1'b1;
                    end else begin
                        state_nxt = SHIFT_LOW;
                        fall      = 1'b1;
                        next_bit  = 1'b1;
                    end
                end
            end
            QUIET: begin
                if (quiet_done) begin
                    if (need_frame) begin
                        state_nxt = CS_SETUP;
                        start     = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        cs_low_nxt = (state_nxt == CS_SETUP) || (state_nxt == SHIFT_LOW) || (state_nxt == SHIFT_HIGH);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= ((state_nxt != state) || (state == IDLE)) ? '0 : cnt + CNT_W'(1);
        end
    end

    // SPI pins, shift registers, selection bookkeeping and results.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            ADC_CS_N     <= 1'b1;
            ADC_SCLK     <= 1'b1;
            ADC_SADDR    <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= 3'd0;
            sample_data  <= 12'd0;
            adc_data     <= '0;
            bit_cnt      <= 4'd0;
            cmd_sr       <= 16'd0;
            shreg        <= 12'd0;
            pend         <= 8'd0;
            rr_ptr       <= 3'd7;
            cur_ch       <= 3'd0;
            cur_grant    <= 1'b0;
            pending_ch   <= 3'd0;
            pending_want <= 1'b0;
        end else begin
            ADC_CS_N     <= !cs_low_nxt;
            ADC_SCLK     <= (state_nxt != SHIFT_LOW);
            busy         <= (state_nxt != IDLE);
            sample_valid <= 1'b0;
            // A request arriving with the grant-clear of the same bit wins.
            pend         <= (pend & ~prio_clr) | prio_req;
            if (start) begin
                cur_ch    <= sel_ch;
                cur_grant <= sel_grant;
                cmd_sr    <= {2'b00, sel_ch, 11'd0};
                bit_cnt   <= 4'd0;
                if (!prio_hit && rr_hit) rr_ptr <= rr_idx;
            end
            if (fall) begin
                ADC_SADDR <= cmd_sr[15];
                cmd_sr    <= {cmd_sr[14:0], 1'b0};
            end
            if (next_bit) bit_cnt <= bit_cnt + 4'd1;
            if (rise && (bit_cnt >= 4'd4)) shreg <= {shreg[10:0], ADC_SDAT};
            // Data of this frame belongs to the address sent in the previous one.
            if (frame_end) begin
                if (pending_want) begin
                    sample_valid         <= 1'b1;
                    sample_ch            <= pending_ch;
                    sample_data          <= shreg;
                    adc_data[pending_ch] <= shreg;
                end
                pending_ch   <= cur_ch;
                pending_want <= cur_grant;
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: frame-timeline reference model checked every
// cycle, an ADC serial model, directed scenarios and randomized traffic.
module tb_adc_scan_scheduler;

    localparam int C       = 25;
    localparam int QH      = 2;
    localparam int CS_RISE = 33 * C;
    localparam int FRAME   = (33 + QH) * C;

    logic             CLOCK_50 = 1'b0;
    logic             reset_n;
    logic             run;
    logic [7:0]       ch_enable;
    logic [7:0]       prio_req;
    logic             ADC_CS_N, ADC_SCLK, ADC_SADDR;
    logic             ADC_SDAT = 1'b0;
    logic             sample_valid;
    logic [2:0]       sample_ch;
    logic [11:0]      sample_data;
    logic [7:0][11:0] adc_data;
    logic             busy;

    adc_scan_scheduler #(.CLK_DIV(C), .QUIET_HALVES(QH)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .run(run), .ch_enable(ch_enable),
        .prio_req(prio_req), .ADC_CS_N(ADC_CS_N), .ADC_SCLK(ADC_SCLK),
        .ADC_SADDR(ADC_SADDR), .ADC_SDAT(ADC_SDAT), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .sample_data(sample_data), .adc_data(adc_data), .busy(busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC: returns the value of the channel addressed in the previous frame.
    logic [11:0] vals [8];
    logic [15:0] dout_sr  = 16'd0;
    logic [15:0] addr_sr  = 16'd0;
    logic [2:0]  adc_prev = 3'd0;

    always @(negedge ADC_CS_N) begin
        dout_sr = {4'b0000, vals[adc_prev]};
        addr_sr = 16'd0;
    end
    always @(negedge ADC_SCLK) if (ADC_CS_N == 1'b0) begin
        ADC_SDAT = dout_sr[15];
        dout_sr  = {dout_sr[14:0], 1'b0};
    end
    always @(posedge ADC_SCLK) if (ADC_CS_N == 1'b0) addr_sr = {addr_sr[14:0], ADC_SADDR};
    always @(posedge ADC_CS_N) adc_prev = addr_sr[13:11];

    // Reference model: frame timeline position mt (-1 = idle) plus scheduler bookkeeping.
    int          mt = -1;
    logic [7:0]  pend_m;
    int          rr_m, pch_m, cur_addr;
    bit          pwant_m, cur_grant;
    logic [11:0] adc_m [8];
    logic [15:0] cmd_m;
    bit          exp_sv;
    logic [2:0]  exp_sch;
    logic [11:0] exp_sdat;

    always @(posedge CLOCK_50) begin
        logic [7:0][11:0] exp_adc;
        bit               exp_cs, exp_sclk, exp_saddr;
        int               k;
        cyc++;
        if (!reset_n) begin
            mt = -1; pend_m = 8'd0; rr_m = 7; pch_m = 0; pwant_m = 0;
            cur_addr = 0; cur_grant = 0; cmd_m = 16'd0; exp_sv = 0;
            for (int i = 0; i < 8; i++) adc_m[i] = 12'd0;
        end else begin
            exp_sv = 0;
            if (mt >= 0) mt++;
            if (mt == CS_RISE) begin
                if (pwant_m) begin
                    exp_sv        = 1;
                    exp_sch       = 3'(pch_m);
                    exp_sdat      = vals[pch_m];
                    adc_m[pch_m]  = vals[pch_m];
                end
                pch_m   = cur_addr;
                pwant_m = cur_grant;
            end
            if (mt == FRAME) mt = -1;
            if (mt == -1 && run && (pend_m != 8'd0 || ch_enable != 8'd0 || pwant_m)) begin
                if (pend_m != 8'd0) begin
                    for (int i = 7; i >= 0; i--) if (pend_m[i]) cur_addr = i;
                    pend_m[cur_addr] = 1'b0;
                    cur_grant = 1;
                end else if (ch_enable != 8'd0) begin
                    for (int j = 8; j >= 1; j--) if (ch_enable[(rr_m + j) % 8]) cur_addr = (rr_m + j) % 8;
                    rr_m = cur_addr;
                    cur_grant = 1;
                end else begin
                    cur_addr  = pch_m;
                    cur_grant = 0;
                end
                cmd_m = 16'(cur_addr) << 11;
                mt = 0;
            end
            pend_m = pend_m | prio_req;
        end
        #1;
        exp_cs   = (mt < 0) || (mt >= CS_RISE);
        exp_sclk = exp_cs || (((mt / C) % 2) == 0);
        if (mt < C) exp_saddr = 0;
        else begin
            k = (mt - C) / (2 * C);
            if (k > 15) k = 15;
            exp_saddr = cmd_m[15 - k];
        end
        for (int i = 0; i < 8; i++) exp_adc[i] = adc_m[i];
        chk("cs_n", ADC_CS_N, exp_cs);
        chk("sclk", ADC_SCLK, exp_sclk);
        chk("saddr", ADC_SADDR, exp_saddr);
        chk("busy", busy, (mt >= 0));
        chk("sample_valid", sample_valid, exp_sv);
        if (exp_sv) begin
            chk("sample_ch", sample_ch, exp_sch);
            chk("sample_data", sample_data, exp_sdat);
        end
        chk("adc_data", adc_data, exp_adc);
    end

    // Event log of observed pin activity for the directed scenarios.
    int         cs_fall_t[$], cs_rise_t[$], sclk_fall_t[$];
    logic [2:0] frame_addr[$];
    logic [2:0] st_ch[$];
    logic [11:0] st_dat[$];
    bit         prev_cs = 1'b1, prev_sclk = 1'b1;

    always @(posedge CLOCK_50) begin
        #1;
        if (prev_cs && !ADC_CS_N) cs_fall_t.push_back(cyc);
        if (!prev_cs && ADC_CS_N && reset_n) begin
            cs_rise_t.push_back(cyc);
            frame_addr.push_back(adc_prev);
        end
        if (prev_sclk && !ADC_SCLK && !ADC_CS_N) sclk_fall_t.push_back(cyc);
        if (sample_valid) begin
            st_ch.push_back(sample_ch);
            st_dat.push_back(sample_data);
        end
        prev_cs   = ADC_CS_N;
        prev_sclk = ADC_SCLK;
    end

    task automatic clear_log();
        cs_fall_t.delete(); cs_rise_t.delete(); sclk_fall_t.delete();
        frame_addr.delete(); st_ch.delete(); st_dat.delete();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int w = 0;
        while (frame_addr.size() < n && w < budget) begin
            @(negedge CLOCK_50);
            w++;
        end
        chk("frames_seen", (frame_addr.size() >= n), 1'b1);
    endtask

    task automatic wait_cs_falls(input int n, input int budget);
        int w = 0;
        while (cs_fall_t.size() < n && w < budget) begin
            @(negedge CLOCK_50);
            w++;
        end
        chk("cs_falls_seen", (cs_fall_t.size() >= n), 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int w = 0;
        while (busy && w < budget) begin
            @(negedge CLOCK_50);
            w++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_800_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b1; run = 1'b0; ch_enable = 8'h00; prio_req = 8'h00;
        for (int i = 0; i < 8; i++) vals[i] = 12'(12'h100 + i);
        #5 reset_n = 1'b0;
        #1;
        chk("rst_cs_n", ADC_CS_N, 1'b1);
        chk("rst_sclk", ADC_SCLK, 1'b1);
        chk("rst_saddr", ADC_SADDR, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sample_valid", sample_valid, 1'b0);
        chk("rst_sample_ch", sample_ch, 3'd0);
        chk("rst_sample_data", sample_data, 12'd0);
        chk("rst_adc_data", adc_data, 96'd0);
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;

        // Round robin over channels 0 and 2, plus frame timing.
        clear_log();
        ch_enable = 8'h05; run = 1'b1;
        wait_frames(3, 4 * FRAME);
        run = 1'b0;
        if (frame_addr.size() >= 3 && st_ch.size() >= 2 && sclk_fall_t.size() >= 2 && cs_fall_t.size() >= 2) begin
            chk("rr_addr0", frame_addr[0], 3'd0);
            chk("rr_addr1", frame_addr[1], 3'd2);
            chk("rr_addr2", frame_addr[2], 3'd0);
            chk("rr_strobes", st_ch.size(), 2);
            chk("rr_st0_ch", st_ch[0], 3'd0);
            chk("rr_st0_data", st_dat[0], 12'h100);
            chk("rr_st1_ch", st_ch[1], 3'd2);
            chk("rr_st1_data", st_dat[1], 12'h102);
            chk("t_first_fall", sclk_fall_t[0] - cs_fall_t[0], 25);
            chk("t_sclk_period", sclk_fall_t[1] - sclk_fall_t[0], 50);
            chk("t_cs_high", cs_rise_t[0] - cs_fall_t[0], 825);
            chk("t_frame", cs_fall_t[1] - cs_fall_t[0], 875);
        end
        wait_idle(2 * FRAME);

        // Priority request to channel 7 during a frame.
        do_reset();
        clear_log();
        ch_enable = 8'h01; run = 1'b1;
        repeat (100) @(negedge CLOCK_50);
        prio_req = 8'h80;
        @(negedge CLOCK_50);
        prio_req = 8'h00;
        wait_frames(3, 4 * FRAME);
        run = 1'b0;
        if (frame_addr.size() >= 3 && st_ch.size() >= 2) begin
            chk("pr_addr0", frame_addr[0], 3'd0);
            chk("pr_addr1", frame_addr[1], 3'd7);
            chk("pr_addr2", frame_addr[2], 3'd0);
            chk("pr_st0_ch", st_ch[0], 3'd0);
            chk("pr_st1_ch", st_ch[1], 3'd7);
            chk("pr_st1_data", st_dat[1], 12'h107);
        end
        wait_idle(2 * FRAME);

        // Mask cleared mid-frame: one flush frame, then idle.
        do_reset();
        clear_log();
        ch_enable = 8'h04; run = 1'b1;
        repeat (100) @(negedge CLOCK_50);
        ch_enable = 8'h00;
        wait_idle(4 * FRAME);
        repeat (2 * FRAME) @(negedge CLOCK_50);
        chk("dr_frames", frame_addr.size(), 2);
        chk("dr_strobes", st_ch.size(), 1);
        if (st_ch.size() >= 1 && frame_addr.size() >= 2) begin
            chk("dr_addr1", frame_addr[1], 3'd2);
            chk("dr_st_ch", st_ch[0], 3'd2);
            chk("dr_st_data", st_dat[0], 12'h102);
        end
        chk("dr_busy", busy, 1'b0);
        chk("dr_cs_n", ADC_CS_N, 1'b1);
        run = 1'b0;

        // Reset in the middle of bit 8.
        clear_log();
        ch_enable = 8'h01; run = 1'b1;
        wait_frames(2, 3 * FRAME);
        chk("rs_adc0_pre", adc_data[0], 12'h100);
        wait_cs_falls(3, 2 * FRAME);
        repeat (17 * C + 5) @(negedge CLOCK_50);
        reset_n = 1'b0;
        #1;
        chk("rs_cs_n", ADC_CS_N, 1'b1);
        chk("rs_sclk", ADC_SCLK, 1'b1);
        chk("rs_sample_valid", sample_valid, 1'b0);
        chk("rs_adc_data", adc_data, 96'd0);
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        clear_log();
        wait_frames(1, 2 * FRAME);
        chk("rs_first_no_strobe", st_ch.size(), 0);
        wait_frames(2, 2 * FRAME);
        if (st_ch.size() >= 1) chk("rs_second_data", st_dat[0], 12'h100);
        run = 1'b0;
        wait_idle(2 * FRAME);

        // Randomized traffic against the model.
        for (int i = 0; i < 8; i++) vals[i] = 12'($urandom);
        run = 1'b1;
        ch_enable = 8'($urandom);
        for (int n = 0; n < 25000; n++) begin
            @(negedge CLOCK_50);
            reset_n  = ($urandom_range(0, 9999) != 0);
            prio_req = ($urandom_range(0, 299) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 999) == 0)
                ch_enable = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 2999) == 0) run = !run;
        end
        @(negedge CLOCK_50);
        reset_n = 1'b1; prio_req = 8'h00; run = 1'b0;
        wait_idle(2 * FRAME);
        repeat (4) @(negedge CLOCK_50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
